// File: rtl/oled_frame_seq_if.sv
// Byte-stream and framebuffer-read bus between oled_frame_seq (master) and
// the SPI byte shifter / framebuffer RAM (slave).
interface oled_frame_seq_if;
    // Byte stream towards the SPI shifter
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_dc;
    // Framebuffer read port: fb_data is valid exactly one cycle after fb_rd_en
    logic       fb_rd_en;
    logic [9:0] fb_addr;
    logic [7:0] fb_data;

    modport master (
        output tx_valid, tx_data, tx_dc, fb_rd_en, fb_addr,
        input  tx_ready, fb_data
    );

    modport slave (
        input  tx_valid, tx_data, tx_dc, fb_rd_en, fb_addr,
        output tx_ready, fb_data
    );
endinterface

// File: rtl/oled_frame_seq.sv
// SSD1306 power-up, init-ROM and full-frame (1024-byte) streaming sequencer.
// Optional macro OLED_FRAME_SEQ_AUTO_REFRESH_EN: frames restart continuously from IDLE.
module oled_frame_seq #(
    parameter int RST_CYCLES  = 250,
    parameter int WAIT_CYCLES = 2500
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_req,
    oled_frame_seq_if.master bus,
    output logic             oled_res_n,
    output logic             oled_cs_n,
    output logic             busy,
    output logic             frame_done
);
    localparam int RST_W  = $clog2(RST_CYCLES + 1);
    localparam int WAIT_W = $clog2(WAIT_CYCLES + 1);
    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYCLES - 1);
    localparam logic [4:0]        INIT_LAST = 5'd24;
    localparam logic [4:0]        WIN_LAST  = 5'd5;
    localparam logic [9:0]        ADDR_LAST = 10'd1023;

    typedef enum logic [2:0] {
        RST_HOLD,
        RST_WAIT,
        INIT,
        IDLE,
        WIN,
        FETCH,
        SEND
    } state_t;

    function automatic logic [7:0] init_rom(input logic [4:0] idx);
        case (idx)
            5'd0:    return 8'hAE;
            5'd1:    return 8'hD5;
            5'd2:    return 8'h80;
            5'd3:    return 8'hA8;
            5'd4:    return 8'h3F;
            5'd5:    return 8'hD3;
            5'd6:    return 8'h00;
            5'd7:    return 8'h40;
            5'd8:    return 8'h8D;
            5'd9:    return 8'h14;
            5'd10:   return 8'h20;
            5'd11:   return 8'h00;
            5'd12:   return 8'hA1;
            5'd13:   return 8'hC8;
            5'd14:   return 8'hDA;
            5'd15:   return 8'h12;
            5'd16:   return 8'h81;
            5'd17:   return 8'hCF;
            5'd18:   return 8'hD9;
            5'd19:   return 8'hF1;
            5'd20:   return 8'hDB;
            5'd21:   return 8'h40;
            5'd22:   return 8'hA4;
            5'd23:   return 8'hA6;
            5'd24:   return 8'hAF;
            default: return 8'h00;
        endcase
    endfunction

    // Column window 0..127, page window 0..7: covers the whole 128x64 panel.
    function automatic logic [7:0] win_rom(input logic [4:0] idx);
        case (idx)
            5'd0:    return 8'h21;
            5'd1:    return 8'h00;
            5'd2:    return 8'h7F;
            5'd3:    return 8'h22;
            5'd4:    return 8'h00;
            5'd5:    return 8'h07;
            default: return 8'h00;
        endcase
    endfunction

    state_t              r_state,    w_state;
    logic [RST_W-1:0]    r_rst_cnt,  w_rst_cnt;
    logic [WAIT_W-1:0]   r_wait_cnt, w_wait_cnt;
    logic [4:0]          r_idx,      w_idx;
    logic                r_tx_valid, w_tx_valid;
    logic [7:0]          r_tx_data,  w_tx_data;
    logic                r_tx_dc,    w_tx_dc;
    logic                r_fb_rd_en, w_fb_rd_en;
    logic [9:0]          r_fb_addr,  w_fb_addr;
    logic                r_pending,  w_pending;
    logic                w_frame_done;
    logic                w_xfer;
    logic                w_start;

    assign w_xfer = r_tx_valid & bus.tx_ready;

`ifdef OLED_FRAME_SEQ_AUTO_REFRESH_EN
    logic w_unused_frame_req;
    assign w_unused_frame_req = frame_req;
    assign w_start            = 1'b1;
`else
    assign w_start            = frame_req | r_pending;
`endif

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path leaves it unassigned and no latch is inferred.
        w_state      = r_state;
        w_rst_cnt    = r_rst_cnt;
        w_wait_cnt   = r_wait_cnt;
        w_idx        = r_idx;
        w_tx_valid   = r_tx_valid;
        w_tx_data    = r_tx_data;
        w_tx_dc      = r_tx_dc;
        w_fb_rd_en   = r_fb_rd_en;
        w_fb_addr    = r_fb_addr;
        w_pending    = r_pending;
        w_frame_done = 1'b0;

`ifndef OLED_FRAME_SEQ_AUTO_REFRESH_EN
        // Only one request is remembered while a frame or power-up is in progress.
        if (frame_req && (r_state != IDLE)) begin
            w_pending = 1'b1;
        end
`endif

        case (r_state)
            RST_HOLD: begin
                if (r_rst_cnt == RST_LAST) begin
                    w_state   = RST_WAIT;
                    w_rst_cnt = '0;
                end else begin
                    w_rst_cnt = r_rst_cnt + 1'b1;
                end
            end

            RST_WAIT: begin
                if (r_wait_cnt == WAIT_LAST) begin
                    w_state    = INIT;
                    w_wait_cnt = '0;
                    w_idx      = '0;
                    w_tx_valid = 1'b1;
                    w_tx_data  = init_rom(5'd0);
                    w_tx_dc    = 1'b0;
                end else begin
                    w_wait_cnt = r_wait_cnt + 1'b1;
                end
            end

            INIT: begin
                if (w_xfer) begin
                    if (r_idx == INIT_LAST) begin
                        w_state    = IDLE;
                        w_idx      = '0;
                        w_tx_valid = 1'b0;
                    end else begin
                        w_idx     = r_idx + 5'd1;
                        w_tx_data = init_rom(r_idx + 5'd1);
                    end
                end
            end

            IDLE: begin
                if (w_start) begin
                    w_state    = WIN;
                    w_pending  = 1'b0;
                    w_idx      = '0;
                    w_tx_valid = 1'b1;
                    w_tx_data  = win_rom(5'd0);
                    w_tx_dc    = 1'b0;
                end
            end

            WIN: begin
                if (w_xfer) begin
                    if (r_idx == WIN_LAST) begin
                        w_state    = FETCH;
                        w_idx      = '0;
                        w_tx_valid = 1'b0;
                        w_fb_addr  = '0;
                        w_fb_rd_en = 1'b1;
                    end else begin
                        w_idx     = r_idx + 5'd1;
                        w_tx_data = win_rom(r_idx + 5'd1);
                    end
                end
            end

            // First FETCH cycle drives the read strobe; the second captures the RAM output.
            FETCH: begin
                if (r_fb_rd_en) begin
                    w_fb_rd_en = 1'b0;
                end else begin
                    w_state    = SEND;
                    w_tx_valid = 1'b1;
                    w_tx_data  = bus.fb_data;
                    w_tx_dc    = 1'b1;
                end
            end

            SEND: begin
                if (w_xfer) begin
                    w_tx_valid = 1'b0;
                    if (r_fb_addr == ADDR_LAST) begin
                        w_state      = IDLE;
                        w_fb_addr    = '0;
                        w_frame_done = 1'b1;
                    end else begin
                        w_state    = FETCH;
                        w_fb_addr  = r_fb_addr + 10'd1;
                        w_fb_rd_en = 1'b1;
                    end
                end
            end

            default: begin
                w_state = RST_HOLD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state    <= RST_HOLD;
            r_rst_cnt  <= '0;
            r_wait_cnt <= '0;
            r_idx      <= '0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
            r_tx_dc    <= 1'b0;
            r_fb_rd_en <= 1'b0;
            r_fb_addr  <= '0;
            r_pending  <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_rst_cnt  <= w_rst_cnt;
            r_wait_cnt <= w_wait_cnt;
            r_idx      <= w_idx;
            r_tx_valid <= w_tx_valid;
            r_tx_data  <= w_tx_data;
            r_tx_dc    <= w_tx_dc;
            r_fb_rd_en <= w_fb_rd_en;
            r_fb_addr  <= w_fb_addr;
            r_pending  <= w_pending;
        end
    end

    assign bus.tx_valid = r_tx_valid;
    assign bus.tx_data  = r_tx_data;
    assign bus.tx_dc    = r_tx_dc;
    assign bus.fb_rd_en = r_fb_rd_en;
    assign bus.fb_addr  = r_fb_addr;

    assign oled_res_n = (r_state != RST_HOLD);
    assign oled_cs_n  = (r_state == RST_HOLD) || (r_state == RST_WAIT);
    assign busy       = (r_state != IDLE);
    assign frame_done = w_frame_done;
endmodule
